wb_arbiter: RTL and testbench

Round-robin arbiter that shares the single Wishbone-style memory slave port between N bus masters: the processor core, a DMA engine and a debug port. It sits between the masters' M_wb ports and the memory/peripheral interconnect. It also enforces a per-transaction timeout so that a non-responding slave cannot hang a master.

---
 rtl/wb_arbiter_pkg.sv | 23 ++
 rtl/wb_arbiter_if.sv | 43 ++++
 rtl/wb_arbiter_rr_picker.sv | 35 +++
 rtl/wb_arbiter.sv | 104 ++++++++++
 tb/tb_wb_arbiter.sv | 252 +++++++++++++++++++++++++
 5 files changed

// File: rtl/wb_arbiter_pkg.sv
// wb_arbiter shared types and constants.
// Bus widths fall back to 32 bits when the build does not provide them.
`ifndef ADDR_SIZE
`define ADDR_SIZE 32
`endif
`ifndef WORD_SIZE
`define WORD_SIZE 32
`endif

package wb_arbiter_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  localparam int DEF_TIMEOUT = 255;

  localparam logic [`WORD_SIZE-1:0] ERR_RDATA = '0;

  localparam int CNT_W = 16;

endpackage

// File: rtl/wb_arbiter_if.sv
// Master-side and slave-side bus signals of the arbiter.
// slave: the arbiter's view; master: the environment's view.
`ifndef ADDR_SIZE
`define ADDR_SIZE 32
`endif
`ifndef WORD_SIZE
`define WORD_SIZE 32
`endif

interface wb_arbiter_if #(
  parameter int N_MASTERS = 2
);
  import wb_arbiter_pkg::*;

  logic [N_MASTERS-1:0]                  M_cs;
  logic [N_MASTERS-1:0]                  M_we;
  logic [N_MASTERS-1:0][`ADDR_SIZE-1:0]  M_addr;
  logic [N_MASTERS-1:0][`WORD_SIZE-1:0]  M_wdata;
  logic [`WORD_SIZE-1:0]                 M_rdata;
  logic [N_MASTERS-1:0]                  M_ack;

  logic [`ADDR_SIZE-1:0]                 S_addr;
  logic                                  S_cs;
  logic                                  S_we;
  logic [`WORD_SIZE-1:0]                 S_wdata;
  logic [`WORD_SIZE-1:0]                 S_rdata;
  logic                                  S_ack;

  modport slave (
    input  M_cs, M_we, M_addr, M_wdata,
    input  S_rdata, S_ack,
    output M_rdata, M_ack,
    output S_addr, S_cs, S_we, S_wdata
  );

  modport master (
    output M_cs, M_we, M_addr, M_wdata,
    output S_rdata, S_ack,
    input  M_rdata, M_ack,
    input  S_addr, S_cs, S_we, S_wdata
  );

endinterface

// File: rtl/wb_arbiter_rr_picker.sv
// Combinational round-robin pick: search starts one past
// the last grant and wraps modulo N_MASTERS.
module rr_picker
  import wb_arbiter_pkg::*;
#(
  parameter int N_MASTERS = 2
) (
  input  logic [N_MASTERS-1:0] req,
  input  logic [2:0]           last,
  output logic                 valid,
  output logic [2:0]           winner
);

  localparam int IW = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;

  int            idx;
  logic [IW-1:0] sel;

  // walk farthest-to-nearest so the nearest requester wins
  always_comb begin
    valid  = 1'b0;
    winner = '0;
    idx    = 0;
    sel    = '0;
    for (int i = N_MASTERS; i >= 1; i--) begin
      idx = (int'(last) + i) % N_MASTERS;
      sel = IW'(idx);
      if (req[sel]) begin
        valid  = 1'b1;
        winner = 3'(idx);
      end
    end
  end

endmodule

// File: rtl/wb_arbiter.sv
// Round-robin Wishbone arbiter with per-transaction timeout.
// One transaction in flight; one idle cycle between grants.
module wb_arbiter
  import wb_arbiter_pkg::*;
#(
  parameter int N_MASTERS = 2,
  parameter int TIMEOUT   = DEF_TIMEOUT
) (
  input  logic        Clk,
  input  logic        Rst,
  wb_arbiter_if.slave bus,
  output logic [2:0]  Grant_id,
  output logic        Busy,
  output logic        Bus_err
);

  localparam int IW = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t               state;
  logic [2:0]           grant;
  logic [2:0]           last_grant;
  logic [CNT_W-1:0]     cnt;

  logic                 pick_valid;
  logic [2:0]           pick_id;
  logic [IW-1:0]        gi;
  logic                 busy_st;
  logic                 cs_g;
  logic                 timeout;
  logic                 done;
  logic [N_MASTERS-1:0] ack_v;

  assign gi      = grant[IW-1:0];
  assign busy_st = (state == BUSY);
  assign cs_g    = bus.M_cs[gi];
  // a real ack on the last cycle wins over the timeout
  assign timeout = busy_st && cs_g && !bus.S_ack
                && (cnt == TO_LAST);
  assign done    = bus.S_ack || !cs_g || timeout;

  assign Grant_id = grant;
  assign Busy     = busy_st;
  assign Bus_err  = timeout;

  rr_picker #(
    .N_MASTERS(N_MASTERS)
  ) u_pick (
    .req    (bus.M_cs),
    .last   (last_grant),
    .valid  (pick_valid),
    .winner (pick_id)
  );

  // route the granted master to the slave; all quiet when idle
  always_comb begin
    ack_v       = '0;
    bus.S_cs    = 1'b0;
    bus.S_we    = 1'b0;
    bus.S_addr  = '0;
    bus.S_wdata = '0;
    bus.M_rdata = '0;
    if (busy_st) begin
      bus.S_cs    = cs_g && !timeout;
      bus.S_we    = bus.M_we[gi];
      bus.S_addr  = bus.M_addr[gi];
      bus.S_wdata = bus.M_wdata[gi];
      bus.M_rdata = timeout ? ERR_RDATA : bus.S_rdata;
      ack_v[gi]   = bus.S_ack || timeout;
    end
    bus.M_ack = ack_v;
  end

  // arbitration FSM, grant history and saturating timeout counter
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state      <= IDLE;
      grant      <= '0;
      last_grant <= 3'(N_MASTERS - 1);
      cnt        <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (pick_valid) begin
            grant <= pick_id;
            cnt   <= '0;
            state <= BUSY;
          end
        end
        BUSY: begin
          if (done) begin
            state      <= IDLE;
            last_grant <= grant;
          end else if (cnt != CNT_MAX) begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_arbiter.sv
// Randomized scoreboard bench for wb_arbiter.
// Stimulus predicts each cycle; a negedge monitor compares.
`ifndef ADDR_SIZE
`define ADDR_SIZE 32
`endif
`ifndef WORD_SIZE
`define WORD_SIZE 32
`endif

module tb_wb_arbiter;

  localparam int N      = 3;
  localparam int TMO    = 8;
  localparam int CYCLES = 4000;

  typedef struct {
    bit                    busy;
    int                    gid;
    bit                    scs;
    bit                    ack;
    bit                    we;
    logic [`ADDR_SIZE-1:0] addr;
    logic [`WORD_SIZE-1:0] wdata;
  } cyc_t;

  typedef struct {
    int                    m;
    logic [`WORD_SIZE-1:0] rdata;
    bit                    err;
  } ack_t;

  logic       Clk = 1'b0;
  logic       Rst = 1'b1;
  logic [2:0] Grant_id;
  logic       Busy;
  logic       Bus_err;

  int vectors     = 0;
  int miscompares = 0;

  cyc_t cyc_q[$];
  ack_t ack_q[$];

  wb_arbiter_if #(.N_MASTERS(N)) bus ();

  wb_arbiter #(
    .N_MASTERS(N),
    .TIMEOUT  (TMO)
  ) dut (
    .Clk      (Clk),
    .Rst      (Rst),
    .bus      (bus),
    .Grant_id (Grant_id),
    .Busy     (Busy),
    .Bus_err  (Bus_err)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h (t=%0t)",
               name, act, exp, $time);
    end
  endtask

  // master-side state of the bench
  bit                    req[N];
  bit                    mwe[N];
  bit                    done_m[N];
  logic [`ADDR_SIZE-1:0] maddr[N];
  logic [`WORD_SIZE-1:0] mwdata[N];

  task automatic new_req(input int m);
    req[m]    = 1'b1;
    maddr[m]  = $urandom;
    mwe[m]    = 1'($urandom_range(0, 1));
    mwdata[m] = $urandom;
  endtask

  // reference model: who owns the bus, for how long, who went last
  int  owner    = -1;
  int  ptr      = N - 1;
  int  last_gid = 0;
  int  elapsed  = 0;
  int  mode     = 0;
  int  n_rst    = 0;
  bit  stray_next = 1'b0;

  initial begin
    bit                    rst_now;
    bit                    sack;
    bit                    to;
    logic [`WORD_SIZE-1:0] srd;
    cyc_t                  c;
    ack_t                  a;
    int                    o;
    int                    m;

    bus.S_ack   = 1'b0;
    bus.S_rdata = '0;
    bus.M_cs    = '0;
    bus.M_we    = '0;
    bus.M_addr  = '0;
    bus.M_wdata = '0;
    for (int i = 0; i < N; i++) begin
      req[i] = 1'b0; mwe[i] = 1'b0; done_m[i] = 1'b0;
      maddr[i] = '0; mwdata[i] = '0;
    end

    repeat (2) @(posedge Clk);
    #1;

    for (int cyc = 0; cyc < CYCLES; cyc++) begin
      // masters: drop after ack, maybe issue a fresh request
      for (int i = 0; i < N; i++) begin
        if (done_m[i]) begin
          req[i]    = 1'b0;
          done_m[i] = 1'b0;
          if ($urandom_range(0, 1) == 1) new_req(i);
        end else if (!req[i] && $urandom_range(0, 2) == 0) begin
          new_req(i);
        end
      end

      rst_now = 1'b0;
      if (cyc > 50 && owner >= 0 && elapsed < TMO - 1
          && n_rst < 6 && $urandom_range(0, 29) == 0)
        rst_now = 1'b1;

      if (!rst_now && owner >= 0 && req[owner]
          && $urandom_range(0, 24) == 0)
        req[owner] = 1'b0;

      sack = 1'b0;
      if (rst_now)
        sack = 1'b0;
      else if (owner >= 0) begin
        case (mode)
          0:       sack = ($urandom_range(0, 2) == 0);
          1:       sack = 1'b0;
          default: sack = (elapsed == TMO - 1);
        endcase
      end else
        sack = stray_next || ($urandom_range(0, 5) == 0);
      stray_next = rst_now;
      srd = $urandom;

      Rst         = rst_now;
      bus.S_ack   = sack;
      bus.S_rdata = srd;
      for (int i = 0; i < N; i++) begin
        bus.M_cs[i]    = req[i];
        bus.M_we[i]    = mwe[i];
        bus.M_addr[i]  = maddr[i];
        bus.M_wdata[i] = mwdata[i];
      end

      c.busy = 1'b0; c.gid = last_gid; c.scs = 1'b0;
      c.ack = 1'b0;  c.we = 1'b0; c.addr = '0; c.wdata = '0;

      if (owner >= 0) begin
        o  = owner;
        to = req[o] && !sack && (elapsed == TMO - 1);
        c.busy  = 1'b1;
        c.gid   = o;
        c.scs   = req[o] && !to;
        c.we    = mwe[o];
        c.addr  = maddr[o];
        c.wdata = mwdata[o];
        if (rst_now) begin
          owner = -1; ptr = N - 1; last_gid = 0; n_rst++;
        end else if (sack || to) begin
          c.ack   = 1'b1;
          a.m     = o;
          a.rdata = sack ? srd : '0;
          a.err   = !sack;
          ack_q.push_back(a);
          owner = -1; ptr = o; done_m[o] = 1'b1;
        end else if (!req[o]) begin
          owner = -1; ptr = o;
        end else begin
          elapsed++;
        end
      end else begin
        for (int k = 1; k <= N; k++) begin
          m = (ptr + k) % N;
          if (owner < 0 && req[m]) begin
            owner    = m;
            last_gid = m;
            elapsed  = 0;
            mode     = ($urandom_range(0, 5) < 4) ? 0
                     : int'($urandom_range(1, 2));
          end
        end
      end
      cyc_q.push_back(c);

      @(posedge Clk);
      #1;
    end

    Rst = 1'b0;
    @(negedge Clk);
    #1;
    chk("ack_queue_drained", 32'(ack_q.size()), 32'd0);
    chk("cycle_queue_drained", 32'(cyc_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

  cyc_t mc;
  ack_t ma;

  // monitor: per-cycle bus state plus ack events against the queue
  always @(negedge Clk) begin
    if (cyc_q.size() > 0) begin
      mc = cyc_q.pop_front();
      chk("busy", 32'(Busy), 32'(mc.busy));
      chk("grant_id", 32'(Grant_id), 32'(mc.gid));
      chk("s_cs", 32'(bus.S_cs), 32'(mc.scs));
      chk("ack_present", 32'(bus.M_ack != '0), 32'(mc.ack));
      if (mc.scs) begin
        chk("s_addr", 32'(bus.S_addr), 32'(mc.addr));
        chk("s_we", 32'(bus.S_we), 32'(mc.we));
        chk("s_wdata", 32'(bus.S_wdata), 32'(mc.wdata));
      end
      if (!mc.busy) begin
        chk("idle_s_addr", 32'(bus.S_addr), 32'd0);
        chk("idle_s_wdata", 32'(bus.S_wdata), 32'd0);
        chk("idle_s_we", 32'(bus.S_we), 32'd0);
        chk("idle_m_rdata", 32'(bus.M_rdata), 32'd0);
      end
      if (bus.M_ack != '0 || Bus_err) begin
        if (ack_q.size() == 0) begin
          chk("spurious_ack_err", 32'({bus.M_ack, Bus_err}), 32'd0);
        end else begin
          ma = ack_q.pop_front();
          chk("ack_vector", 32'(bus.M_ack), 32'd1 << ma.m);
          chk("ack_rdata", 32'(bus.M_rdata), 32'(ma.rdata));
          chk("bus_err", 32'(Bus_err), 32'(ma.err));
        end
      end
    end
  end

endmodule
